// File: rtl/ysyx_22050039_pkg.sv
// Shared types for the ysyx_22050039 multiply/divide unit.
package ysyx_22050039_pkg;

  localparam int WORD_BITS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/ysyx_22050039_mdu_div.sv
// Restoring divider core on magnitudes: one quotient bit per cycle, N=32 (word) or XLEN steps.
// done is high during the last step; quot/rem carry that step's result combinationally.
module ysyx_22050039_mdu_div #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);
  import ysyx_22050039_pkg::*;

  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] q_q, q_d, r_q, r_d, d_q, d_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   r_sh, diff;

  always_comb begin
    r_sh  = {r_q, q_q[XLEN-1]};
    diff  = r_sh - {1'b0, d_q};
    quot  = {q_q[XLEN-2:0], ~diff[XLEN]};
    rem   = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
    done  = (cnt_q == CW'(1));
    q_d   = q_q;
    r_d   = r_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (start) begin
      // Word dividends are left-aligned so the first step sees bit 31.
      q_d   = word ? (dividend << (XLEN - WORD_BITS)) : dividend;
      r_d   = '0;
      d_d   = divisor;
      cnt_d = word ? CW'(WORD_BITS) : CW'(XLEN);
    end else if (cnt_q != '0) begin
      q_d   = quot;
      r_d   = rem;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      r_q   <= r_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ysyx_22050039_mdu.sv
// RV64M iterative multiply/divide unit: latency N+1 (N=32 word, else XLEN), early-outs 1; result held until out_ready.
// Divider present only when YSYX_22050039_MDU_DIV_EN is defined; otherwise ops 4-7 report illegal.
module ysyx_22050039_mdu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            busy
);
  import ysyx_22050039_pkg::*;

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = XLEN'($signed(32'h8000_0000));

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_d, op_e;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d, result_q, result_d;
  logic              word_q, word_d, neg_q, neg_d, illegal_q, illegal_d;

  logic              s1_signed, s2_signed, is_div, accept, illegal_req, a_neg, b_neg;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag;

  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
    return w ? XLEN'($signed(v[WORD_BITS-1:0])) : v;
  endfunction

  always_comb begin
    op_e      = mdu_op_e'(op);
    s1_signed = op_e inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    s2_signed = op_e inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    is_div    = op[2];
    a_ext = word ? XLEN'($signed({s1_signed & src1[WORD_BITS-1], src1[WORD_BITS-1:0]})) : src1;
    b_ext = word ? XLEN'($signed({s2_signed & src2[WORD_BITS-1], src2[WORD_BITS-1:0]})) : src2;
    a_neg = s1_signed & a_ext[XLEN-1];
    b_neg = s2_signed & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    illegal_req = word && ((XLEN == WORD_BITS) || (op_e inside {OP_MULH, OP_MULHSU, OP_MULHU}));
`ifndef YSYX_22050039_MDU_DIV_EN
    illegal_req = illegal_req || is_div;
`endif
    accept = in_valid && (state_q == ST_IDLE) && !flush;
  end

`ifdef YSYX_22050039_MDU_DIV_EN
  logic            div_zero, div_ovf, div_start, div_done, rneg_q, rneg_d;
  logic [XLEN-1:0] div_quot, div_rem, div_qs, div_rs;

  always_comb begin
    div_zero  = is_div && (b_ext == '0);
    div_ovf   = is_div && s1_signed && (a_ext == (word ? MIN_W : MIN_X)) && (b_ext == '1);
    div_start = accept && is_div && !illegal_req && !div_zero && !div_ovf;
    rneg_d    = accept ? a_neg : rneg_q;
    div_qs    = neg_q ? -div_quot : div_quot;
    div_rs    = rneg_q ? -div_rem : div_rem;
  end

  ysyx_22050039_mdu_div #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .flush    (flush),
    .word     (word),
    .dividend (a_mag),
    .divisor  (b_mag),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );
`endif

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] acc_nxt, mul_prod, mul_sprod;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_nxt   = {mul_sum, acc_q[XLEN-1:1]};
    // After N shifts of a word op the product sits XLEN-32 bits above bit 0.
    mul_prod  = word_q ? (acc_nxt >> (XLEN - WORD_BITS)) : acc_nxt;
    mul_sprod = neg_q ? -mul_prod : mul_prod;
    mul_res   = (op_q == OP_MUL) ? mul_sprod[XLEN-1:0] : mul_sprod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    word_d    = word_q;
    neg_d     = neg_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        op_d      = op_e;
        word_d    = word;
        neg_d     = a_neg ^ b_neg;
        cnt_d     = word ? CW'(WORD_BITS) : CW'(XLEN);
        acc_d     = {{XLEN{1'b0}}, b_mag};
        mcand_d   = a_mag;
        illegal_d = 1'b0;
        if (illegal_req) begin
          result_d  = '0;
          illegal_d = 1'b1;
          state_d   = ST_DONE;
        end
`ifdef YSYX_22050039_MDU_DIV_EN
        else if (div_zero) begin
          result_d = wfix(word, op[1] ? a_ext : '1);
          state_d  = ST_DONE;
        end else if (div_ovf) begin
          result_d = wfix(word, op[1] ? '0 : a_ext);
          state_d  = ST_DONE;
        end else if (is_div) begin
          state_d = ST_DIV;
        end
`endif
        else begin
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = wfix(word_q, mul_res);
          state_d  = ST_DONE;
        end
      end
`ifdef YSYX_22050039_MDU_DIV_EN
      ST_DIV: if (div_done) begin
        result_d = wfix(word_q, op_q[1] ? div_rs : div_qs);
        state_d  = ST_DONE;
      end
`endif
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      word_q    <= 1'b0;
      neg_q     <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifdef YSYX_22050039_MDU_DIV_EN
      rneg_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      word_q    <= word_d;
      neg_q     <= neg_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
`ifdef YSYX_22050039_MDU_DIV_EN
      rneg_q    <= rneg_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;
  assign illegal   = illegal_q;

endmodule
